// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// muldiv_unit : iterative radix-2 MULT/MULTU/DIV/DIVU unit with HI/LO pair
// Rev 1.0
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int c_CW = $clog2(WIDTH);
  localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(WIDTH - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_FIX  = 2'd2;

  logic [1:0]         r_state;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [c_CW-1:0]    r_cnt;
  logic               r_div;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;

  // Unsigned ops latch zero sign bits, so the correction stage needs no op check.
  logic             w_signed_op;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;

  assign w_signed_op = ~op[0];
  assign w_a_neg     = w_signed_op & src_a[WIDTH-1];
  assign w_b_neg     = w_signed_op & src_b[WIDTH-1];
  assign w_abs_a     = w_a_neg ? -src_a : src_a;
  assign w_abs_b     = w_b_neg ? -src_b : src_b;

  // Multiply step: conditional add into the upper half, then shift right with carry.
  logic [WIDTH:0] w_mul_sum;
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);

  // Divide step: the shifted partial remainder needs one extra bit for the compare.
  logic [WIDTH:0]   w_div_shift;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_sub;

  assign w_div_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
  assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_b;

  logic               w_b_zero;
  logic               w_mul_neg;
  logic               w_quo_neg;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_b_zero  = (r_b == '0);
  assign w_mul_neg = r_sign_a ^ r_sign_b;
  assign w_quo_neg = (r_sign_a ^ r_sign_b) & ~w_b_zero;
  assign w_prod    = w_mul_neg ? -r_acc : r_acc;
  assign w_quo_fix = w_quo_neg ? -r_quo : r_quo;
  // With a zero divisor the remainder holds |src_a|; restoring its sign returns src_a.
  assign w_rem_fix = r_sign_a ? -r_rem : r_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_div    <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
          if (start) begin
            r_state  <= c_RUN;
            r_busy   <= 1'b1;
            r_div    <= op[1];
            r_sign_a <= w_a_neg;
            r_sign_b <= w_b_neg;
            r_a      <= w_abs_a;
            r_b      <= w_abs_b;
            r_acc    <= {{WIDTH{1'b0}}, w_abs_b};
            r_rem    <= '0;
            r_quo    <= w_abs_a;
            r_cnt    <= '0;
          end
        end
        c_RUN: begin
          if (r_div) begin
            r_rem <= w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_div_ge};
          end else begin
            r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
          end
          if (r_cnt == c_CNT_LAST) begin
            r_state <= c_FIX;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        c_FIX: begin
          if (r_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// tb_muldiv_unit : scoreboard bench for muldiv_unit
// Rev 1.0
// ============================================================================
module tb_muldiv_unit;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] sb_q[$];
  logic [63:0] r_exp;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference: SV arithmetic on sign-extended 64-bit values.
  function automatic logic [63:0] model(input logic [1:0] m_op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [63:0] sp;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    sa = a;
    sb = b;
    case (m_op)
      2'd0: begin sp = sa * sb; return sp; end
      2'd1: return {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        return {sr, sq};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check_val("spurious_done", 32'd1, 32'd0);
      end else begin
        r_exp = sb_q.pop_front();
        check_val("hi", hi, r_exp[63:32]);
        check_val("lo", lo, r_exp[31:0]);
      end
    end
  end

  // Drives start for one edge (E0); returns #1 after E0.
  task automatic launch(input logic [1:0] l_op, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [63:0] exp);
    @(posedge clk); #1;
    start = 1'b1; op = l_op; src_a = a; src_b = b;
    if (push) sb_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits for done; checks remaining latency, busy duration and pulse width.
  task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
    int lat;
    int busy_cnt;
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    check_val({tag, "_latency"}, lat, exp_lat);
    if (exp_busy > 0) check_val({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    check_val({tag, "_busy_at_done"}, busy, 1'b0);
    @(posedge clk); #1;
    check_val({tag, "_done_pulse"}, done, 1'b0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] l_op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e_hi, input logic [31:0] e_lo);
    launch(l_op, a, b, 1'b1, {e_hi, e_lo});
    wait_done(tag, 33, 33);
  endtask

  initial begin
    logic [31:0] hold_hi;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rop;
    int          n_done;

    rst_n = 1'b0; start = 1'b0; op = 2'd0; src_a = '0; src_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_hi", hi, 32'd0);
    check_val("rst_lo", lo, 32'd0);
    rst_n = 1'b1;

    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",  2'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("mult_min",  2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("div_neg",   2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",      2'd3, 32'd100,       32'd7,         32'd2,         32'd14);
    run_op("div_ovf",   2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_zero", 2'd3, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF);
    run_op("div_zero",  2'd2, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);

    // start/write collisions while busy are ignored; hi/lo hold through RUN.
    hold_hi = hi;
    launch(2'd1, 32'd6, 32'd7, 1'b1, {32'd0, 32'd42});
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = 2'd2; hi_we = 1'b1; wdata = 32'h0000_DEAD; src_a = 32'd9; src_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    check_val("busy_write_ignored", hi, hold_hi);
    wait_done("busy_collide", 28, 0);

    lo_we = 1'b1; wdata = 32'h0000_1234;
    @(posedge clk); #1;
    lo_we = 1'b0;
    check_val("mtlo_lo", lo, 32'h0000_1234);
    check_val("mtlo_hi", hi, 32'd0);

    // Write and start in the same IDLE cycle: write lands, result overwrites later.
    @(posedge clk); #1;
    start = 1'b1; op = 2'd3; src_a = 32'd50; src_b = 32'd8;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    sb_q.push_back({32'd2, 32'd6});
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check_val("same_cycle_hi", hi, 32'hCAFE_F00D);
    check_val("same_cycle_lo", lo, 32'hCAFE_F00D);
    wait_done("same_cycle", 33, 0);

    // Asynchronous reset mid-operation aborts without any result.
    launch(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 64'd0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("abort_busy", busy, 1'b0);
    check_val("abort_done", done, 1'b0);
    check_val("abort_hi", hi, 32'd0);
    check_val("abort_lo", lo, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check_val("abort_no_done", n_done, 0);
    run_op("after_abort", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14);

    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if (rb == 32'hFFFF_FFFF || rb == 32'd0) rb = 32'd3;
      launch(rop, ra, rb, 1'b1, model(rop, ra, rb));
      wait_done("random", 33, 33);
    end

    check_val("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
